// File: rtl/filt_y_val.sv
// Admittance-change filter: applies one branch change dY to the Y-memory rows of
// both terminal nodes and hands each updated diagonal/off-diagonal pair downstream.
module filt_y_val (
    input  logic         clock,
    input  logic         reset,
    input  logic         filt_EN,
    input  logic [15:0]  chng_row,
    input  logic [15:0]  chng_col,
    input  logic [23:0]  chng_real,
    input  logic [23:0]  chng_img,
    input  logic [255:0] ymem_data,
    input  logic         yMemDataReady,
    input  logic         exModDone,
    output logic [15:0]  op_y_row,
    output logic [47:0]  op_yVal1,
    output logic [47:0]  op_yVal2,
    output logic         op_EX_EN,
    output logic         op_Done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT1 = 3'd1,
        EX1   = 3'd2,
        WAIT2 = 3'd3,
        EX2   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state;

    // Latched change record; data only, so it carries no reset.
    logic        [15:0] row_q;
    logic        [15:0] col_q;
    logic signed [23:0] dre_q;
    logic signed [23:0] dim_q;

    logic        [15:0] key_diag;
    logic        [15:0] key_off;
    logic        [47:0] ent_diag;
    logic        [47:0] ent_off;
    logic        [47:0] val_sum;
    logic        [47:0] val_diff;
    logic               shunt;

    function automatic logic signed [23:0] wrap_add(input logic signed [23:0] a,
                                                    input logic signed [23:0] b);
        return a + b;
    endfunction

    function automatic logic signed [23:0] wrap_sub(input logic signed [23:0] a,
                                                    input logic signed [23:0] b);
        return a - b;
    endfunction

    // First slot (lowest index) whose column field equals key; zero when absent.
    function automatic logic [47:0] lookup(input logic [255:0] word,
                                           input logic [15:0]  key);
        logic [47:0] res;
        logic        found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && word[64*k+48 +: 16] == key) begin
                res   = word[64*k +: 48];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [47:0] apply_dy(input logic [47:0]        entry,
                                             input logic signed [23:0] re,
                                             input logic signed [23:0] im,
                                             input logic               negate);
        logic signed [23:0] e_re;
        logic signed [23:0] e_im;
        logic signed [23:0] r_re;
        logic signed [23:0] r_im;
        e_re = entry[47:24];
        e_im = entry[23:0];
        if (negate) begin
            r_re = wrap_sub(e_re, re);
            r_im = wrap_sub(e_im, im);
        end else begin
            r_re = wrap_add(e_re, re);
            r_im = wrap_add(e_im, im);
        end
        return {r_re, r_im};
    endfunction

    // Second pass looks at row col, so the diagonal/off-diagonal keys swap.
    assign key_diag = (state == WAIT2) ? col_q : row_q;
    assign key_off  = (state == WAIT2) ? row_q : col_q;
    assign ent_diag = lookup(ymem_data, key_diag);
    assign ent_off  = lookup(ymem_data, key_off);
    assign val_sum  = apply_dy(ent_diag, dre_q, dim_q, 1'b0);
    assign val_diff = apply_dy(ent_off,  dre_q, dim_q, 1'b1);
    assign shunt    = (row_q == col_q);

    always_ff @(posedge clock) begin
        if (state == IDLE && filt_EN) begin
            row_q <= chng_row;
            col_q <= chng_col;
            dre_q <= chng_real;
            dim_q <= chng_img;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_y_row <= '0;
            op_yVal1 <= '0;
            op_yVal2 <= '0;
            op_EX_EN <= 1'b0;
            op_Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_Done <= 1'b0;
                    if (filt_EN) begin
                        op_y_row <= chng_row;
                        state    <= WAIT1;
                    end
                end
                WAIT1, WAIT2: begin
                    if (yMemDataReady) begin
                        op_yVal2 <= val_sum;
                        op_yVal1 <= shunt ? val_sum : val_diff;
                        op_EX_EN <= 1'b1;
                        state    <= (state == WAIT1) ? EX1 : EX2;
                    end
                end
                EX1: begin
                    if (exModDone) begin
                        op_EX_EN <= 1'b0;
                        if (shunt) begin
                            op_Done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            op_y_row <= col_q;
                            state    <= WAIT2;
                        end
                    end
                end
                EX2: begin
                    if (exModDone) begin
                        op_EX_EN <= 1'b0;
                        op_Done  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    op_Done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    op_EX_EN <= 1'b0;
                    op_Done  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filt_y_val.sv
// Directed bench for filt_y_val: two-pass change, shunt wrap, missing entry,
// handshake stalls, mid-operation abort and back-to-back timing.
module tb_filt_y_val;

    logic         clock;
    logic         reset;
    logic         filt_EN;
    logic [15:0]  chng_row;
    logic [15:0]  chng_col;
    logic [23:0]  chng_real;
    logic [23:0]  chng_img;
    logic [255:0] ymem_data;
    logic         yMemDataReady;
    logic         exModDone;
    logic [15:0]  op_y_row;
    logic [47:0]  op_yVal1;
    logic [47:0]  op_yVal2;
    logic         op_EX_EN;
    logic         op_Done;

    int total;
    int fails;

    filt_y_val dut (
        .clock         (clock),
        .reset         (reset),
        .filt_EN       (filt_EN),
        .chng_row      (chng_row),
        .chng_col      (chng_col),
        .chng_real     (chng_real),
        .chng_img      (chng_img),
        .ymem_data     (ymem_data),
        .yMemDataReady (yMemDataReady),
        .exModDone     (exModDone),
        .op_y_row      (op_y_row),
        .op_yVal1      (op_yVal1),
        .op_yVal2      (op_yVal2),
        .op_EX_EN      (op_EX_EN),
        .op_Done       (op_Done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] slot(input logic [15:0] c, input logic [23:0] re,
                                         input logic [23:0] im);
        return {c, re, im};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_row"},  48'(op_y_row), 48'h0);
        check({tag, "_val1"}, op_yVal1,      48'h0);
        check({tag, "_val2"}, op_yVal2,      48'h0);
        check({tag, "_exen"}, 48'(op_EX_EN), 48'h0);
        check({tag, "_done"}, 48'(op_Done),  48'h0);
    endtask

    task automatic start(input logic [15:0] r, input logic [15:0] c,
                         input logic [23:0] re, input logic [23:0] im);
        filt_EN   = 1'b1;
        chng_row  = r;
        chng_col  = c;
        chng_real = re;
        chng_img  = im;
        step();
        filt_EN   = 1'b0;
        chng_row  = 16'hDEAD;
        chng_col  = 16'hBEEF;
        chng_real = 24'h123456;
        chng_img  = 24'h654321;
    endtask

    initial begin
        total         = 0;
        fails         = 0;
        reset         = 1'b1;
        filt_EN       = 1'b0;
        chng_row      = '0;
        chng_col      = '0;
        chng_real     = '0;
        chng_img      = '0;
        ymem_data     = '0;
        yMemDataReady = 1'b0;
        exModDone     = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        step();
        step();
        check_all_zero("idle_after_reset");

        // Two-pass change row=2 col=5, dY=(0x10,-0x10)
        start(16'd2, 16'd5, 24'h000010, 24'hFFFFF0);
        check("p1_row", 48'(op_y_row), 48'd2);
        check("p1_exen_wait", 48'(op_EX_EN), 48'd0);
        ymem_data = {64'h0, 64'h0, slot(16'd5, 24'hFFFF00, 24'h000050),
                     slot(16'd2, 24'h000100, 24'h000200)};
        yMemDataReady = 1'b1;
        step();
        yMemDataReady = 1'b0;
        check("p1_val2", op_yVal2, 48'h000110_0001F0);
        check("p1_val1", op_yVal1, 48'hFFFEF0_000060);
        check("p1_exen", 48'(op_EX_EN), 48'd1);
        exModDone = 1'b1;
        step();
        exModDone = 1'b0;
        check("p2_row", 48'(op_y_row), 48'd5);
        check("p2_exen_wait", 48'(op_EX_EN), 48'd0);
        ymem_data = {slot(16'd5, 24'h0, 24'h0), slot(16'd2, 24'h0, 24'h0), 64'h0, 64'h0};
        yMemDataReady = 1'b1;
        step();
        yMemDataReady = 1'b0;
        check("p2_val1", op_yVal1, 48'hFFFFF0_000010);
        check("p2_val2", op_yVal2, 48'h000010_FFFFF0);
        check("p2_exen", 48'(op_EX_EN), 48'd1);
        exModDone = 1'b1;
        step();
        exModDone = 1'b0;
        check("p2_done_hi", 48'(op_Done), 48'd1);
        check("p2_exen_lo", 48'(op_EX_EN), 48'd0);
        step();
        check("p2_done_lo", 48'(op_Done), 48'd0);

        // Shunt with real-part wrap
        start(16'd3, 16'd3, 24'h000001, 24'h000000);
        ymem_data = {64'h0, 64'h0, 64'h0, slot(16'd3, 24'h7FFFFF, 24'h000000)};
        yMemDataReady = 1'b1;
        step();
        yMemDataReady = 1'b0;
        check("sh_val1", op_yVal1, 48'h800000_000000);
        check("sh_val2", op_yVal2, 48'h800000_000000);
        exModDone = 1'b1;
        step();
        exModDone = 1'b0;
        check("sh_done_hi", 48'(op_Done), 48'd1);
        check("sh_row_hold", 48'(op_y_row), 48'd3);
        step();
        check("sh_done_lo", 48'(op_Done), 48'd0);

        // Missing entry plus both handshake stalls
        start(16'd1, 16'd7, 24'h000004, 24'h000001);
        step();
        step();
        step();
        check("stall_rdy_exen", 48'(op_EX_EN), 48'd0);
        check("stall_rdy_val1", op_yVal1, 48'h800000_000000);
        ymem_data = {64'h0, 64'h0, 64'h0, slot(16'd1, 24'h0, 24'h0)};
        yMemDataReady = 1'b1;
        step();
        check("miss_val1", op_yVal1, 48'hFFFFFC_FFFFFF);
        check("miss_val2", op_yVal2, 48'h000004_000001);
        ymem_data = {4{slot(16'd7, 24'h0AAAAA, 24'h0BBBBB)}};
        step();
        step();
        step();
        step();
        yMemDataReady = 1'b0;
        check("stall_done_exen", 48'(op_EX_EN), 48'd1);
        check("stall_done_row", 48'(op_y_row), 48'd1);
        check("stall_done_val1", op_yVal1, 48'hFFFFFC_FFFFFF);
        exModDone = 1'b1;
        step();
        check("miss_p2_row", 48'(op_y_row), 48'd7);
        // exModDone kept high: accepted on the first EX2 edge
        ymem_data = {64'h0, slot(16'd7, 24'h000555, 24'h0), slot(16'd1, 24'h000010, 24'h000020),
                     slot(16'd7, 24'h000100, 24'h000000)};
        yMemDataReady = 1'b1;
        step();
        yMemDataReady = 1'b0;
        check("miss_p2_val2", op_yVal2, 48'h000104_000001);
        check("miss_p2_val1", op_yVal1, 48'h00000C_00001F);
        step();
        exModDone = 1'b0;
        check("miss_done_hi", 48'(op_Done), 48'd1);

        // Back-to-back request held during DONE, then abort in EX1
        filt_EN   = 1'b1;
        chng_row  = 16'd4;
        chng_col  = 16'd6;
        chng_real = 24'h000002;
        chng_img  = 24'h000002;
        step();
        check("b2b_idle_row", 48'(op_y_row), 48'd7);
        check("b2b_idle_done", 48'(op_Done), 48'd0);
        step();
        filt_EN = 1'b0;
        check("b2b_latch_row", 48'(op_y_row), 48'd4);
        ymem_data = {64'h0, 64'h0, slot(16'd6, 24'h000020, 24'h000020),
                     slot(16'd4, 24'h000010, 24'h000010)};
        yMemDataReady = 1'b1;
        step();
        yMemDataReady = 1'b0;
        check("abort_pre_exen", 48'(op_EX_EN), 48'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort_async");
        exModDone = 1'b1;
        step();
        check("abort_no_done", 48'(op_Done), 48'd0);
        exModDone = 1'b0;
        reset = 1'b0;
        step();
        check_all_zero("abort_idle");

        // Fresh change with ready/done held high: 6-cycle pass
        yMemDataReady = 1'b1;
        exModDone     = 1'b1;
        start(16'd4, 16'd6, 24'h000002, 24'h000002);
        check("fast_e1_row", 48'(op_y_row), 48'd4);
        step();
        check("fast_e2_val2", op_yVal2, 48'h000012_000012);
        check("fast_e2_val1", op_yVal1, 48'h00001E_00001E);
        check("fast_e2_exen", 48'(op_EX_EN), 48'd1);
        step();
        check("fast_e3_row", 48'(op_y_row), 48'd6);
        check("fast_e3_exen", 48'(op_EX_EN), 48'd0);
        step();
        check("fast_e4_val2", op_yVal2, 48'h000022_000022);
        check("fast_e4_val1", op_yVal1, 48'h00000E_00000E);
        step();
        check("fast_e5_done", 48'(op_Done), 48'd1);
        yMemDataReady = 1'b0;
        exModDone     = 1'b0;
        step();
        check("fast_e6_done", 48'(op_Done), 48'd0);
        step();
        check("fast_idle_row", 48'(op_y_row), 48'd6);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
